ahfp_add: RTL and testbench
===========================

AHFP_ADD -- requirements
Module: ahfp_add

Interface
REQ-001 The block SHALL have parameter SUB, default 1, meaning 1 = result is dataa minus datab and 0 = result is dataa plus datab.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: synchronous, active-low reset sampled on rising clk.
REQ-004 The block SHALL have port dataa, input, 32 bits: IEEE-754 binary32 minuend (or first addend when SUB=0).
REQ-005 The block SHALL have port datab, input, 32 bits: IEEE-754 binary32 subtrahend (or second addend when SUB=0).
REQ-006 The block SHALL have port result, output, 32 bits, registered: IEEE-754 binary32 result.

Function
REQ-007 The block SHALL set result on each rising clk with rst_n high to the value computed from the dataa/datab sampled at that edge; latency is exactly 1 cycle, throughput 1 operation/cycle, no handshake.
REQ-008 For SUB=1 the block SHALL compute dataa - datab by inverting datab's sign bit and then performing the add path.
REQ-009 The add path SHALL unpack sign, 8-bit exponent, and 24-bit significand with implicit 1 for nonzero exponents.
REQ-010 The add path SHALL order the operands by magnitude, comparing exponent then mantissa.
REQ-011 The add path SHALL right-shift the smaller significand by the exponent difference, keeping guard, round and sticky bits.
REQ-012 A shift of 26 or more SHALL reduce the smaller operand to sticky only.
REQ-013 For like effective signs the add path SHALL add significands; on carry-out it SHALL shift right 1 and increment the exponent.
REQ-014 For unlike effective signs the add path SHALL subtract the smaller from the larger significand and left-normalise using a leading-zero count, decrementing the exponent.
REQ-015 Rounding SHALL be round-to-nearest-even using guard/round/sticky; a mantissa carry from rounding SHALL renormalise and increment the exponent.
REQ-016 The result sign SHALL be the sign of the larger-magnitude operand.
REQ-017 An exact cancellation (equal magnitudes, opposite effective signs) SHALL yield +0 (0x00000000).
REQ-018 Subnormal inputs SHALL be treated as zero of the same sign (flush-to-zero).
REQ-019 A result whose exponent underflows below 1 SHALL be flushed to +/-0 with the computed sign.
REQ-020 Exponent overflow at or above 255 after rounding SHALL yield +/-infinity (0x7F800000 / 0xFF800000).
REQ-021 Any NaN input SHALL yield canonical NaN 0x7FC00000.
REQ-022 Infinity minus the same-signed infinity (effective) SHALL yield 0x7FC00000.
REQ-023 Infinity combined with a finite operand SHALL yield that infinity with its effective sign.
REQ-024 When both inputs are zero, the result SHALL be +0 unless both effective signs are negative, in which case it SHALL be -0.

Reset
REQ-025 While rst_n is low at a rising clk edge, result SHALL be set to 0x00000000; the input sample of that edge is discarded.
REQ-026 On the first rising edge with rst_n high, the block SHALL resume normal operation.
REQ-027 The block SHALL hold no state other than the result register.
REQ-028 Reset asserted mid-stream SHALL drop the in-flight operation.

Verification (SUB=1; result checked one cycle after inputs applied)
REQ-029 A bench SHALL check simple operands: 0x00000000 - 0x00000000 -> 0x00000000; 0x3F800000 - 0x40000000 -> 0xBF800000; 0x40400000 - 0x40600000 -> 0xBF000000.
REQ-030 A bench SHALL check rounding across alignment: 0x43FA0000 - 0x41133333 -> 0x43F56666; 0x3F8E363B - 0x3AA137F4 -> 0x3F8E0DED; 0x46A5E51F - 0x435FAB85 -> 0x46A425C8.
REQ-031 A bench SHALL check sign swap and large exponent gap: 0x41EC0000 - 0x453BF800 -> 0xC53A2000; 0x4640E400 - 0x47F12040 -> 0xC7D903C0.
REQ-032 A bench SHALL check massive cancellation with renormalisation: 0x42FF999A - 0x42FCCCCD -> 0x3FB33340; 0x40000000 - 0x40000000 -> 0x00000000.
REQ-033 A bench SHALL check specials: 0x7F800000 - 0x7F800000 -> 0x7FC00000; 0x7F7FFFFF - 0xFF7FFFFF -> 0x7F800000; 0x7FC00001 - 0x3F800000 -> 0x7FC00000.
REQ-034 A bench SHALL check reset: with result nonzero, drive rst_n=0 for one edge -> result 0x00000000 at that edge regardless of inputs; release -> next edge shows the new difference.

Source files
------------

// File: rtl/ahfp_add.sv
// Single-cycle IEEE-754 binary32 adder/subtractor with round-to-nearest-even.
// Subnormals are flushed to zero; every NaN result is the canonical quiet NaN.
module ahfp_add #(
   parameter bit SUB = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] dataa,
   input  logic [31:0] datab,
   output logic [31:0] result
);

   localparam logic [31:0] QNAN = 32'h7FC0_0000;

   logic        sa_s, sb_s, sl_s, ss_s;
   logic [7:0]  ea_s, eb_s, el_s, es_s, shift_s;
   logic [22:0] fa_s, fb_s, frac_s;
   logic        nan_a_s, nan_b_s, inf_a_s, inf_b_s, zero_a_s, zero_b_s;
   logic [30:0] ka_s, kb_s;
   logic [23:0] sigl_s, sigs_s;
   logic [52:0] wide_s;
   logic [26:0] al_s, as_s, dif_s, norm_s;
   logic [27:0] sum_s;
   logic [4:0]  lz_s;
   logic [9:0]  exp_s, expr_s;
   logic        up_s;
   logic [24:0] mant_s;
   logic [31:0] result_s;

   function automatic logic [4:0] lzc27(input logic [26:0] v);
      logic [4:0] n;
      logic       found;
      n     = 5'd0;
      found = 1'b0;
      for (int i = 26; i >= 0; i--) begin
         if (found) begin
            n = n;
         end else if (v[i]) begin
            found = 1'b1;
         end else begin
            n = n + 5'd1;
         end
      end
      return n;
   endfunction

   // Unpack, classify and order operands by magnitude (subnormals count as zero)
   always_comb begin
      sa_s     = dataa[31];
      ea_s     = dataa[30:23];
      fa_s     = dataa[22:0];
      sb_s     = datab[31] ^ SUB;
      eb_s     = datab[30:23];
      fb_s     = datab[22:0];
      nan_a_s  = (ea_s == 8'hFF) && (fa_s != 23'd0);
      nan_b_s  = (eb_s == 8'hFF) && (fb_s != 23'd0);
      inf_a_s  = (ea_s == 8'hFF) && (fa_s == 23'd0);
      inf_b_s  = (eb_s == 8'hFF) && (fb_s == 23'd0);
      zero_a_s = (ea_s == 8'd0);
      zero_b_s = (eb_s == 8'd0);
      ka_s     = zero_a_s ? 31'd0 : dataa[30:0];
      kb_s     = zero_b_s ? 31'd0 : datab[30:0];
      if (ka_s >= kb_s) begin
         sl_s   = sa_s;
         el_s   = ea_s;
         sigl_s = zero_a_s ? 24'd0 : {1'b1, fa_s};
         ss_s   = sb_s;
         es_s   = eb_s;
         sigs_s = zero_b_s ? 24'd0 : {1'b1, fb_s};
      end else begin
         sl_s   = sb_s;
         el_s   = eb_s;
         sigl_s = zero_b_s ? 24'd0 : {1'b1, fb_s};
         ss_s   = sa_s;
         es_s   = ea_s;
         sigs_s = zero_a_s ? 24'd0 : {1'b1, fa_s};
      end
   end

   // Align, add or subtract, normalise and round
   always_comb begin
      shift_s = el_s - es_s;
      wide_s  = {sigs_s, 29'd0} >> shift_s;
      // Bits shifted past the round position collapse into the sticky bit
      if (shift_s >= 8'd26) begin
         as_s = {26'd0, |sigs_s};
      end else begin
         as_s = {wide_s[52:27], |wide_s[26:0]};
      end
      al_s  = {sigl_s, 3'b000};
      sum_s = {1'b0, al_s} + {1'b0, as_s};
      dif_s = al_s - as_s;
      lz_s  = lzc27(dif_s);
      if (sl_s == ss_s) begin
         if (sum_s[27]) begin
            norm_s = {sum_s[27:2], |sum_s[1:0]};
            exp_s  = {2'b00, el_s} + 10'd1;
         end else begin
            norm_s = sum_s[26:0];
            exp_s  = {2'b00, el_s};
         end
      end else begin
         norm_s = dif_s << lz_s;
         exp_s  = {2'b00, el_s} - {5'd0, lz_s};
      end
      up_s   = norm_s[2] & (norm_s[1] | norm_s[0] | norm_s[3]);
      mant_s = {1'b0, norm_s[26:3]} + {24'd0, up_s};
      if (mant_s[24]) begin
         expr_s = exp_s + 10'd1;
         frac_s = mant_s[23:1];
      end else begin
         expr_s = exp_s;
         frac_s = mant_s[22:0];
      end
   end

   // Special-case priority and final packing
   always_comb begin
      if (nan_a_s || nan_b_s) begin
         result_s = QNAN;
      end else if (inf_a_s && inf_b_s) begin
         result_s = (sa_s == sb_s) ? {sa_s, 8'hFF, 23'd0} : QNAN;
      end else if (inf_a_s) begin
         result_s = {sa_s, 8'hFF, 23'd0};
      end else if (inf_b_s) begin
         result_s = {sb_s, 8'hFF, 23'd0};
      end else if (zero_a_s && zero_b_s) begin
         result_s = {sa_s & sb_s, 31'd0};
      end else if ((sl_s != ss_s) && (dif_s == 27'd0)) begin
         result_s = 32'd0;
      end else if (expr_s[9] || (expr_s == 10'd0)) begin
         result_s = {sl_s, 31'd0};
      end else if (expr_s >= 10'd255) begin
         result_s = {sl_s, 8'hFF, 23'd0};
      end else begin
         result_s = {sl_s, expr_s[7:0], frac_s};
      end
   end

   // Result register: the only state in the block
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         result <= 32'd0;
      end else begin
         result <= result_s;
      end
   end

endmodule

// File: tb/tb_ahfp_add.sv
// Directed vector bench for ahfp_add (SUB=1): table of operands and hand-computed results.
module tb_ahfp_add;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   localparam int NV = 27;

   logic        clk;
   logic        rst_n;
   logic [31:0] dataa;
   logic [31:0] datab;
   logic [31:0] result;
   int          errors;
   int          checks;
   vec_t        vecs [NV];

   ahfp_add #(.SUB(1'b1)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .dataa  (dataa),
      .datab  (datab),
      .result (result)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] want);
      checks++;
      if (result !== want) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", name, result, want);
      end
   endtask

   task automatic apply(input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      dataa = a;
      datab = b;
      @(posedge clk);
      #1;
   endtask

   initial begin
      errors = 0;
      checks = 0;
      vecs[0]  = '{32'h00000000, 32'h00000000, 32'h00000000};
      vecs[1]  = '{32'h3F800000, 32'h40000000, 32'hBF800000};
      vecs[2]  = '{32'h40400000, 32'h40600000, 32'hBF000000};
      vecs[3]  = '{32'h43FA0000, 32'h41133333, 32'h43F56666};
      vecs[4]  = '{32'h3F8E363B, 32'h3AA137F4, 32'h3F8E0DED};
      vecs[5]  = '{32'h46A5E51F, 32'h435FAB85, 32'h46A425C8};
      vecs[6]  = '{32'h41EC0000, 32'h453BF800, 32'hC53A2000};
      vecs[7]  = '{32'h4640E400, 32'h47F12040, 32'hC7D903C0};
      vecs[8]  = '{32'h42FF999A, 32'h42FCCCCD, 32'h3FB33340};
      vecs[9]  = '{32'h40000000, 32'h40000000, 32'h00000000};
      vecs[10] = '{32'h7F800000, 32'h7F800000, 32'h7FC00000};
      vecs[11] = '{32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000};
      vecs[12] = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000};
      vecs[13] = '{32'h3F800000, 32'hFFC00000, 32'h7FC00000};
      vecs[14] = '{32'h7F800000, 32'hFF800000, 32'h7F800000};
      vecs[15] = '{32'hFF800000, 32'hFF800000, 32'h7FC00000};
      vecs[16] = '{32'h3F800000, 32'h7F800000, 32'hFF800000};
      vecs[17] = '{32'hFF800000, 32'h3F800000, 32'hFF800000};
      vecs[18] = '{32'h80000000, 32'h00000000, 32'h80000000};
      vecs[19] = '{32'h80000000, 32'h80000000, 32'h00000000};
      vecs[20] = '{32'h00000001, 32'h3F800000, 32'hBF800000};
      vecs[21] = '{32'h00800001, 32'h00800000, 32'h00000000};
      vecs[22] = '{32'h3F800000, 32'hBF800000, 32'h40000000};
      vecs[23] = '{32'h4B800000, 32'hBF800000, 32'h4B800000};
      vecs[24] = '{32'h4B800001, 32'hBF800000, 32'h4B800002};
      vecs[25] = '{32'h80800001, 32'h80800000, 32'h80000000};
      vecs[26] = '{32'hBF800000, 32'h3F800000, 32'hC0000000};

      rst_n = 1'b0;
      dataa = 32'h3F800000;
      datab = 32'h40000000;
      @(posedge clk);
      #1;
      check("reset_state", 32'h00000000);

      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < NV; i++) begin
         apply(vecs[i].a, vecs[i].b);
         check($sformatf("vec%0d", i), vecs[i].exp);
      end

      // Mid-stream reset drops the sampled operation, release resumes at once
      apply(32'h3F800000, 32'h40000000);
      check("pre_reset", 32'hBF800000);
      @(negedge clk);
      rst_n = 1'b0;
      dataa = 32'h41EC0000;
      datab = 32'h453BF800;
      @(posedge clk);
      #1;
      check("reset_mid", 32'h00000000);
      @(negedge clk);
      rst_n = 1'b1;
      dataa = 32'h40400000;
      datab = 32'h40600000;
      @(posedge clk);
      #1;
      check("after_release", 32'hBF000000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
